// File: rtl/bottle_presence_classifier.sv
// Purpose : filters ultrasonic distance samples, detects a settled bottle in the
//           chute and emits one classification pulse (250/500/1250 ml or reject)
//           per insertion, re-arming only once the chute reads empty again.
// Latency : distance_out and class_valid update one clk after the sample_valid
//           that causes them. class_valid is a single-cycle pulse.
// Backpressure: none; every sample_valid strobe is consumed, back-to-back allowed.
//
// Ports:
//   clk          - system clock
//   rst          - synchronous, active-low reset
//   sample_in    - raw distance (cm), qualified by sample_valid
//   sample_valid - one-cycle strobe for sample_in
//   distance_out - filtered distance for the display path
//   bottle_class - 01=250 ml, 10=500 ml, 11=1250 ml, 00=reject; held between pulses
//   class_valid  - one-cycle pulse when bottle_class is updated
//   reject       - high from a reject classification until the chute is empty again
//   busy         - high whenever the classifier is not in its EMPTY state
//
// Optional build macro BPC_AVERAGE_EN: distance_out and the classification input
// become the mean of the last 4 accepted samples, and a lock additionally needs
// 4 samples of history collected since the bottle arrived.

module bottle_presence_classifier #(
    parameter int WIDTH        = 12,
    parameter int STABLE_COUNT = 8,
    parameter int TOLERANCE    = 2,
    parameter int MAX_SETTLE   = 64,
    parameter int EMPTY_MIN    = 25,
    parameter int D1250_MAX    = 10,
    parameter int D500_MAX     = 17,
    parameter int D250_MAX     = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] distance_out,
    output logic [1:0]       bottle_class,
    output logic             class_valid,
    output logic             reject,
    output logic             busy
);

    localparam int CNT_W = 4;   // holds STABLE_COUNT up to 15
    localparam int SET_W = 8;   // holds MAX_SETTLE up to 255
    localparam int WP1   = WIDTH + 1;

    localparam logic [WIDTH:0]       TOL_W        = WP1'(TOLERANCE);
    localparam logic [CNT_W-1:0]     STABLE_W     = CNT_W'(STABLE_COUNT);
    localparam logic [SET_W-1:0]     SETTLE_MAX_W = SET_W'(MAX_SETTLE);
    localparam logic [WIDTH-1:0]     EMPTY_W      = WIDTH'(EMPTY_MIN);
    localparam logic [WIDTH-1:0]     D1250_W      = WIDTH'(D1250_MAX);
    localparam logic [WIDTH-1:0]     D500_W       = WIDTH'(D500_MAX);
    localparam logic [WIDTH-1:0]     D250_W       = WIDTH'(D250_MAX);

    localparam logic [1:0] CLS_REJECT = 2'b00;
    localparam logic [1:0] CLS_250    = 2'b01;
    localparam logic [1:0] CLS_500    = 2'b10;
    localparam logic [1:0] CLS_1250   = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_SETTLING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [WIDTH-1:0]   ref_q;
    logic [CNT_W-1:0]   stable_q;
    logic [SET_W-1:0]   settle_q;
    logic [WIDTH-1:0]   distance_q;
    logic [1:0]         class_q;
    logic               class_valid_q;
    logic               reject_q;
    logic               busy_q;

    // Next-state of the stability tracker (already gated by sample_valid)
    logic [WIDTH-1:0]   ref_d;
    logic [CNT_W-1:0]   stable_d;
    logic [SET_W-1:0]   settle_d;
    logic [WIDTH:0]     abs_diff;

    // Classification source and readiness, mode dependent
    logic [WIDTH-1:0]   class_src;
    logic               class_ready;
    logic [WIDTH-1:0]   dist_src;

    logic               locked_full;
    logic               chute_empty;
    logic               enter_settle;
    logic [1:0]         class_code;

    // Sensor fault (0 cm) and the gap between 250 ml and empty both reject.
    // Thresholds are inclusive so a boundary reading takes the larger bottle.
    function automatic logic [1:0] classify(input logic [WIDTH-1:0] d);
        logic [1:0] c;
        c = CLS_REJECT;
        if (d == '0)
            c = CLS_REJECT;
        else if (d <= D1250_W)
            c = CLS_1250;
        else if (d <= D500_W)
            c = CLS_500;
        else if (d <= D250_W)
            c = CLS_250;
        else
            c = CLS_REJECT;
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Stability tracker: ref holds while samples stay within tolerance,
    // otherwise it jumps to the new sample and the run restarts at 1.
    // ------------------------------------------------------------------
    always_comb begin
        abs_diff = '0;
        ref_d    = ref_q;
        stable_d = stable_q;
        if (sample_in >= ref_q)
            abs_diff = {1'b0, sample_in} - {1'b0, ref_q};
        else
            abs_diff = {1'b0, ref_q} - {1'b0, sample_in};
        if (sample_valid) begin
            if (abs_diff <= TOL_W) begin
                ref_d    = ref_q;
                stable_d = (stable_q >= STABLE_W) ? STABLE_W : stable_q + CNT_W'(1);
            end else begin
                ref_d    = sample_in;
                stable_d = CNT_W'(1);
            end
        end
    end

    // Settle counter saturates at its all-ones value instead of wrapping
    assign settle_d = (settle_q == '1) ? settle_q : settle_q + SET_W'(1);

    assign locked_full  = (stable_d == STABLE_W);
    // Empty detection always uses the tracked reference, not the average
    assign chute_empty  = locked_full && (ref_d >= EMPTY_W);
    assign enter_settle = sample_valid && (state_q == ST_EMPTY) && (sample_in < EMPTY_W);

`ifdef BPC_AVERAGE_EN
    // ------------------------------------------------------------------
    // 4-sample moving average. History restarts when a bottle arrives so
    // the mean never mixes empty-chute readings into the classification.
    // ------------------------------------------------------------------
    logic [3:0][WIDTH-1:0] hist_q;
    logic [3:0][WIDTH-1:0] hist_d;
    logic [2:0]            hist_cnt_q;
    logic [2:0]            hist_cnt_d;
    logic [WIDTH+1:0]      hist_sum;

    always_comb begin
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        if (enter_settle) begin
            hist_d     = '0;
            hist_d[0]  = sample_in;
            hist_cnt_d = 3'd1;
        end else if (sample_valid) begin
            hist_d     = {hist_q[2:0], sample_in};
            hist_cnt_d = (hist_cnt_q >= 3'd4) ? 3'd4 : hist_cnt_q + 3'd1;
        end
    end

    assign hist_sum = {2'b00, hist_d[0]} + {2'b00, hist_d[1]}
                    + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};

    assign class_src   = WIDTH'(hist_sum >> 2);
    assign dist_src    = class_src;
    assign class_ready = (hist_cnt_d >= 3'd4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q     <= '0;
            hist_cnt_q <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end
`else
    assign class_src   = ref_d;
    assign dist_src    = ref_d;
    assign class_ready = 1'b1;
`endif

    assign class_code = classify(class_src);

    // ------------------------------------------------------------------
    // Presence FSM with registered outputs. Every decision uses the
    // post-update ref/stable values of the sample being consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_EMPTY;
            ref_q         <= '0;
            stable_q      <= '0;
            settle_q      <= '0;
            distance_q    <= '0;
            class_q       <= CLS_REJECT;
            class_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            class_valid_q <= 1'b0;
            if (sample_valid) begin
                ref_q      <= ref_d;
                stable_q   <= stable_d;
                distance_q <= dist_src;
                case (state_q)
                    ST_EMPTY: begin
                        if (enter_settle) begin
                            state_q  <= ST_SETTLING;
                            settle_q <= SET_W'(1);
                            busy_q   <= 1'b1;
                        end
                    end
                    ST_SETTLING: begin
                        settle_q <= settle_d;
                        if (chute_empty) begin
                            // Transient object passed through: no pulse
                            state_q <= ST_EMPTY;
                            busy_q  <= 1'b0;
                        end else if (locked_full && class_ready) begin
                            class_q       <= class_code;
                            reject_q      <= (class_code == CLS_REJECT);
                            class_valid_q <= 1'b1;
                            state_q       <= ST_LOCKED;
                        end else if (settle_d >= SETTLE_MAX_W) begin
                            // Never settled: force a reject so the bottle is counted once
                            class_q       <= CLS_REJECT;
                            reject_q      <= 1'b1;
                            class_valid_q <= 1'b1;
                            state_q       <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (chute_empty) begin
                            state_q  <= ST_EMPTY;
                            reject_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign distance_out = distance_q;
    assign bottle_class = class_q;
    assign class_valid  = class_valid_q;
    assign reject       = reject_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bottle_presence_classifier.sv
module tb_bottle_presence_classifier;

    localparam int SC      = 8;
    localparam int TOL     = 2;
    localparam int MAXSET  = 64;
    localparam int EMPTYM  = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] distance_out;
    logic [1:0]  bottle_class;
    logic        class_valid;
    logic        reject;
    logic        busy;

    bottle_presence_classifier dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .distance_out (distance_out),
        .bottle_class (bottle_class),
        .class_valid  (class_valid),
        .reject       (reject),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    // Reference model: spec rules on plain integers
    int  m_ref, m_stb, m_settle;
    int  m_phase;           // 0 = chute empty, 1 = bottle settling, 2 = bottle counted
    int  e_dist, e_cls;
    bit  e_valid, e_rej, e_busy;

    function automatic int ref_class(input int d);
        if (d == 0)  return 0;
        if (d <= 10) return 3;
        if (d <= 17) return 2;
        if (d <= 22) return 1;
        return 0;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model(input bit r, input bit v, input int s);
        bit full, gone;
        e_valid = 1'b0;
        if (!r) begin
            m_ref = 0; m_stb = 0; m_settle = 0; m_phase = 0;
            e_dist = 0; e_cls = 0; e_rej = 1'b0; e_busy = 1'b0;
            return;
        end
        if (!v) return;
        if (iabs(s - m_ref) <= TOL) m_stb = imin(m_stb + 1, SC);
        else begin m_ref = s; m_stb = 1; end
        e_dist = m_ref;
        full = (m_stb == SC);
        gone = full && (m_ref >= EMPTYM);
        if (m_phase == 0) begin
            if (s < EMPTYM) begin m_phase = 1; m_settle = 1; end
        end else if (m_phase == 1) begin
            m_settle = imin(m_settle + 1, 255);
            if (gone) m_phase = 0;
            else if (full) begin
                e_cls = ref_class(m_ref); e_valid = 1'b1; e_rej = (e_cls == 0); m_phase = 2;
            end else if (m_settle >= MAXSET) begin
                e_cls = 0; e_valid = 1'b1; e_rej = 1'b1; m_phase = 2;
            end
        end else begin
            if (gone) begin m_phase = 0; e_rej = 1'b0; end
        end
        e_busy = (m_phase != 0);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance past the edge, update model, compare
    task automatic step(input bit r, input bit v, input int s);
        rst = r; sample_valid = v; sample_in = 12'(s);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        model(r, v, s);
        if (class_valid === 1'b1) pulses++;
        chk("class_valid",  int'(class_valid),  int'(e_valid));
        chk("bottle_class", int'(bottle_class), e_cls);
        chk("reject",       int'(reject),       int'(e_rej));
        chk("busy",         int'(busy),         int'(e_busy));
        chk("distance_out", int'(distance_out), e_dist);
    endtask

    task automatic burst(input int n, input int s);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, s);
    endtask

    initial begin
        // Reset
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 7);
        step(1'b0, 1'b0, 0);

        // Empty chute readings only
        p0 = pulses;
        burst(20, 30);
        chk("empty_no_pulse", pulses - p0, 0);
        chk("empty_dist", int'(distance_out), 30);
        chk("empty_busy", int'(busy), 0);

        // 500 ml insertion, then empty
        burst(2, 30);
        p0 = pulses;
        burst(7, 15);
        chk("t500_early", pulses - p0, 0);
        burst(1, 15);
        chk("t500_pulse", pulses - p0, 1);
        chk("t500_class", int'(bottle_class), 2);
        burst(8, 30);
        chk("t500_empty_busy", int'(busy), 0);

        // Jittery 1250 ml, extra samples while locked
        p0 = pulses;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 9 : 10);
        chk("t1250_pulse", pulses - p0, 1);
        chk("t1250_class", int'(bottle_class), 3);
        burst(8, 9);
        burst(5, 14);
        chk("t1250_no_repeat", pulses - p0, 1);
        burst(8, 30);

        // Never settles: forced reject at sample 64
        p0 = pulses;
        for (int i = 0; i < 63; i++) step(1'b1, 1'b1, (i % 2 == 0) ? 5 : 20);
        chk("force_early", pulses - p0, 0);
        step(1'b1, 1'b1, 20);
        chk("force_pulse", pulses - p0, 1);
        chk("force_reject", int'(reject), 1);
        burst(7, 40);
        chk("force_reject_held", int'(reject), 1);
        burst(1, 40);
        chk("force_reject_clr", int'(reject), 0);

        // Exact thresholds
        burst(8, 17); chk("thr17", int'(bottle_class), 2); burst(8, 30);
        burst(8, 22); chk("thr22", int'(bottle_class), 1); burst(8, 30);
        burst(8, 24); chk("thr24", int'(bottle_class), 0);
        chk("thr24_rej", int'(reject), 1); burst(8, 30);
        burst(8, 25); chk("thr25_empty", int'(busy), 0);
        burst(8, 0);  chk("fault_rej", int'(reject), 1); burst(8, 30);

        // Reset mid-settle at stable_cnt = 6
        burst(6, 12);
        p0 = pulses;
        step(1'b0, 1'b1, 12);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dist", int'(distance_out), 0);
        burst(7, 12);
        chk("rst_no_pulse", pulses - p0, 0);
        burst(1, 12);
        chk("rst_relock", pulses - p0, 1);
        burst(8, 30);

        // Random insertions with jitter, gaps, occasional resets
        for (int k = 0; k < 60; k++) begin
            int base, n;
            base = $urandom_range(0, 40);
            n    = $urandom_range(3, 24);
            for (int i = 0; i < n; i++) begin
                int s;
                s = base + $urandom_range(0, 6) - 3;
                if (s < 0) s = 0;
                step(($urandom_range(0, 99) != 0), 1'b1, s);
                for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b1, 1'b0, 0);
            end
            burst($urandom_range(8, 12), $urandom_range(25, 60));
        end

        // Unstructured random samples
        for (int i = 0; i < 400; i++)
            step(1'b1, ($urandom_range(0, 3) != 0), $urandom_range(0, 45));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bottle_presence_classifier.md
Name: bottle_presence_classifier

Overview:
- Sits between the ultrasonic ranging stage and the bottle counter.
- Filters raw distance samples (cm) and detects when a bottle has settled in the chute.
- Classifies the settled bottle as 250 ml, 500 ml, 1250 ml or reject, and emits exactly one classification pulse per insertion.
- Re-arms only after the chute is confirmed empty again, so the counter never double-counts one bottle.

Parameters:
- WIDTH, 12, distance sample width in bits.
- STABLE_COUNT, 8, consecutive in-tolerance samples required to lock (range 2..15).
- TOLERANCE, 2, max |sample - ref| in cm still counted as stable.
- MAX_SETTLE, 64, samples allowed in SETTLING before a forced reject (range up to 255).
- EMPTY_MIN, 25, distance >= this means chute empty.
- D1250_MAX, 10, distance <= this classifies as 1250 ml.
- D500_MAX, 17, distance <= this (and > D1250_MAX) classifies as 500 ml.
- D250_MAX, 22, distance <= this (and > D500_MAX) classifies as 250 ml.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1. Reset is synchronous and active-low.
- sample_in, input, WIDTH, raw distance from the ranging stage.
- sample_valid, input, 1, one-cycle strobe marking a new sample_in.
- distance_out, output, WIDTH, filtered distance for the display path.
- bottle_class, output, 2, classification code: 01 = 250, 10 = 500, 11 = 1250, 00 = reject. Held until the next class_valid.
- class_valid, output, 1, one-cycle pulse when bottle_class is updated.
- reject, output, 1, level high from a reject classification until the chute is empty again.
- busy, output, 1, high in any state other than EMPTY.

Behaviour:
- Reset: evaluated on the rising clk edge while rst = 0. It forces:
  - state = EMPTY;
  - ref = 0, stable_cnt = 0, settle_cnt = 0;
  - distance_out = 0, bottle_class = 00, class_valid = 0, reject = 0, busy = 0.
  - sample_valid is ignored in any cycle where rst = 0, including reset asserted mid-settle. No pulse is emitted afterwards.
- Stability tracking, evaluated only on cycles with sample_valid = 1:
  - diff = |sample_in - ref|, computed at WIDTH+1 bits.
  - If diff <= TOLERANCE: stable_cnt = min(stable_cnt + 1, STABLE_COUNT) and ref is held.
  - Otherwise: ref = sample_in and stable_cnt = 1.
  - distance_out = ref, registered, so it updates 1 cycle after sample_valid.
- State machine. All transitions happen on sample_valid cycles and use the updated stable_cnt/ref.
  - EMPTY:
    - If sample_in < EMPTY_MIN: go to SETTLING, settle_cnt = 1.
  - SETTLING:
    - settle_cnt increments on each sample.
    - If stable_cnt reaches STABLE_COUNT: classify ref, pulse class_valid, go to LOCKED.
    - Else if settle_cnt reaches MAX_SETTLE: bottle_class = 00, pulse class_valid, set reject, go to LOCKED.
    - If ref >= EMPTY_MIN with stable_cnt = STABLE_COUNT: go back to EMPTY with no pulse. This covers a transient object.
  - LOCKED:
    - Waits for ref >= EMPTY_MIN with stable_cnt = STABLE_COUNT, then goes to EMPTY and clears reject.
    - Further samples produce no pulse even if the distance changes.
- Classification of ref:
  - ref <= D1250_MAX → 11.
  - ref <= D500_MAX → 10.
  - ref <= D250_MAX → 01.
  - Otherwise (D250_MAX < ref < EMPTY_MIN) → 00 with reject = 1.
  - ref = 0 (sensor fault) → 00 with reject = 1.
- Latency: class_valid rises the cycle after the sample_valid that completes STABLE_COUNT stable samples. It is high for exactly 1 cycle.
- Boundary rules:
  - A sample exactly at EMPTY_MIN counts as empty.
  - A sample exactly at a class threshold takes the larger class.
  - Back-to-back sample_valid on consecutive cycles must be handled.
  - settle_cnt saturates and does not wrap.

Optional Feature:
- Macro: BPC_AVERAGE_EN.
- When defined:
  - a 4-deep shift register holds the last 4 accepted samples;
  - distance_out and the classification input use their sum >> 2 (WIDTH+2-bit accumulator);
  - the history is cleared on reset and on entry to SETTLING;
  - classification occurs only once at least 4 samples are present and stable_cnt = STABLE_COUNT.
- When undefined: ref is used directly, as described above.

Test Plan:
- Reset then 20 samples of 30 → busy = 0, no class_valid, distance_out = 30.
- Samples 30,30 then 8 samples of 15 → class_valid once after the 8th 15, bottle_class = 10; then 8 samples of 30 → busy = 0.
- 8 samples alternating 9/10 (diff 1) → bottle_class = 11 one cycle after the 8th; a second burst of 9s while LOCKED → no extra pulse.
- 64 samples alternating 5/20 → forced pulse at sample 64, bottle_class = 00, reject = 1 until 8 samples of 40.
- Samples at exactly 17, then 22, then 24 (separate insertions) → codes 10, 01, then 00 with reject.
- rst driven low during SETTLING at stable_cnt = 6 → all outputs 0 next cycle; no class_valid after release until a fresh 8-sample lock.
